// File: rtl/fnd_scan_driver.sv
// 4-digit multiplexed seven-segment driver for the SS.cc stopwatch display.
// Converts the binary centisecond count to BCD once per frame and scans one digit per slot.
module fnd_scan_driver #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] bcd,
  input  logic        dp_en,
  output logic [7:0]  seg,
  output logic [3:0]  seg_comm
);

  localparam int unsigned SLOT   = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W  = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int unsigned BIN_W  = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned SREG_W = BIN_W + BCD_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT - 1);
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(9999);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  logic [CNT_W-1:0]  slot_cnt;
  logic [1:0]        idx;
  logic [1:0]        idx_nxt_c;
  logic              slot_tick_c;
  logic              capture_c;
  logic [BIN_W-1:0]  shadow;
  state_t            state, state_nxt;
  logic [3:0]        shift_cnt;
  logic [SREG_W-1:0] sreg;
  logic [SREG_W-1:0] sreg_adj_c;
  logic [BCD_W-1:0]  digits;
  logic [3:0]        nib_c;
  logic [7:0]        seg_nxt_c;

  assign slot_tick_c = (slot_cnt == CNT_MAX);
  assign idx_nxt_c   = idx + 2'd1;
  assign capture_c   = slot_tick_c && (idx == 2'd2);

  function automatic logic [7:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // Slot timing, digit index and frame sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      idx      <= 2'd3;
      shadow   <= '0;
    end else begin
      slot_cnt <= slot_tick_c ? '0 : slot_cnt + CNT_W'(1);
      if (slot_tick_c) idx <= idx_nxt_c;
      if (capture_c) shadow <= (bcd > MAX_VAL) ? MAX_VAL : bcd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture_c) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (shift_cnt == 4'd13) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble ahead of the shift
  always_comb begin
    sreg_adj_c = sreg;
    for (int i = 0; i < 4; i++) begin
      if (sreg[BIN_W + 4*i +: 4] >= 4'd5)
        sreg_adj_c[BIN_W + 4*i +: 4] = sreg[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg      <= '0;
      shift_cnt <= '0;
      digits    <= '0;
    end else begin
      case (state)
        LOAD: begin
          sreg      <= {{BCD_W{1'b0}}, shadow};
          shift_cnt <= '0;
        end
        SHIFT: begin
          sreg      <= {sreg_adj_c[SREG_W-2:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
        end
        DONE:    digits <= sreg[SREG_W-1:BIN_W];
        default: ;
      endcase
    end
  end

  // Next-slot segment code, including dp and leading-zero blanking
  always_comb begin
    case (idx_nxt_c)
      2'd0:    nib_c = digits[3:0];
      2'd1:    nib_c = digits[7:4];
      2'd2:    nib_c = digits[11:8];
      default: nib_c = digits[15:12];
    endcase
    seg_nxt_c = seg_code(nib_c);
    if ((idx_nxt_c == 2'd2) && dp_en) seg_nxt_c[7] = 1'b0;
    if ((idx_nxt_c == 2'd3) && (BLANK_LZ != 0) && (nib_c == 4'd0)) seg_nxt_c = 8'hFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg      <= 8'hFF;
      seg_comm <= 4'b1111;
    end else if (slot_tick_c) begin
      seg      <= seg_nxt_c;
      seg_comm <= ~(4'b0001 << idx_nxt_c);
    end
  end

endmodule
